// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV32I(+M) decode stage.
package decode_pkg;

  localparam int unsigned ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    AluAdd    = 5'd0,
    AluSub    = 5'd1,
    AluAnd    = 5'd2,
    AluOr     = 5'd3,
    AluXor    = 5'd4,
    AluSll    = 5'd5,
    AluSrl    = 5'd6,
    AluSra    = 5'd7,
    AluSlt    = 5'd8,
    AluSltu   = 5'd9,
    AluMul    = 5'd10,
    AluMulh   = 5'd11,
    AluMulhsu = 5'd12,
    AluMulhu  = 5'd13,
    AluDiv    = 5'd14,
    AluDivu   = 5'd15,
    AluRem    = 5'd16,
    AluRemu   = 5'd17
  } alu_op_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmU = 3'd3;
  localparam logic [2:0] ImmJ = 3'd4;

  localparam logic [1:0] OpbRs2  = 2'b00;
  localparam logic [1:0] OpbImm  = 2'b01;
  localparam logic [1:0] OpbFour = 2'b10;

  localparam logic [1:0] WbAlu  = 2'b00;
  localparam logic [1:0] WbLoad = 2'b01;
  localparam logic [1:0] WbPc4  = 2'b10;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       reg_we;
    logic       mem_we;
    logic       mem_re;
    logic [2:0] imm_sel;
    logic       opa_pc;
    logic       rs1_zero_sel;
    logic [1:0] opb_sel;
    logic [1:0] wb_sel;
    logic       pc_src_br;
    logic       pc_src_jal;
    logic       pc_src_jalr;
    logic       br_un;
    logic [2:0] funct3;
    logic       insn_vld;
  } ctrl_t;

  // Base ALU op from funct3; alt selects SUB/SRA (instr[30]).
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    unique case (f3)
      3'b000:  alu_from_f3 = alt ? AluSub : AluAdd;
      3'b001:  alu_from_f3 = AluSll;
      3'b010:  alu_from_f3 = AluSlt;
      3'b011:  alu_from_f3 = AluSltu;
      3'b100:  alu_from_f3 = AluXor;
      3'b101:  alu_from_f3 = alt ? AluSra : AluSrl;
      3'b110:  alu_from_f3 = AluOr;
      default: alu_from_f3 = AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Pure combinational RV32I(+M) decoder: instruction word to control bundle and illegal flag.
module instr_decoder
  import decode_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    ill       = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl_o.reg_we       = 1'b1;
        ctrl_o.imm_sel      = ImmU;
        ctrl_o.rs1_zero_sel = 1'b1;
        ctrl_o.opb_sel      = OpbImm;
      end
      OP_AUIPC: begin
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.imm_sel = ImmU;
        ctrl_o.opa_pc  = 1'b1;
        ctrl_o.opb_sel = OpbImm;
      end
      OP_JAL: begin
        ctrl_o.reg_we     = 1'b1;
        ctrl_o.imm_sel    = ImmJ;
        ctrl_o.opa_pc     = 1'b1;
        ctrl_o.opb_sel    = OpbFour;
        ctrl_o.wb_sel     = WbPc4;
        ctrl_o.pc_src_jal = 1'b1;
      end
      OP_JALR: begin
        ill                = (f3 != 3'b000);
        ctrl_o.reg_we      = 1'b1;
        ctrl_o.imm_sel     = ImmI;
        ctrl_o.opb_sel     = OpbImm;
        ctrl_o.wb_sel      = WbPc4;
        ctrl_o.pc_src_jalr = 1'b1;
      end
      OP_BR: begin
        ill              = (f3[2:1] == 2'b01);
        ctrl_o.imm_sel   = ImmB;
        ctrl_o.opb_sel   = OpbRs2;
        ctrl_o.pc_src_br = 1'b1;
        ctrl_o.br_un     = f3[1];
        // Compare op: BEQ/BNE subtract, signed or unsigned less-than otherwise.
        ctrl_o.alu_op    = !f3[2] ? AluSub : (f3[1] ? AluSltu : AluSlt);
      end
      OP_LD: begin
        ill            = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.mem_re  = 1'b1;
        ctrl_o.imm_sel = ImmI;
        ctrl_o.opb_sel = OpbImm;
        ctrl_o.wb_sel  = WbLoad;
      end
      OP_ST: begin
        ill            = (f3 >= 3'b011);
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.imm_sel = ImmS;
        ctrl_o.opb_sel = OpbImm;
      end
      OP_IMM: begin
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.imm_sel = ImmI;
        ctrl_o.opb_sel = OpbImm;
        ctrl_o.alu_op  = alu_from_f3(f3, 1'b0);
        if (f3 == 3'b001) begin
          ill = (f7 != 7'h00);
        end else if (f3 == 3'b101) begin
          ill           = (f7 != 7'h00) && (f7 != 7'h20);
          ctrl_o.alu_op = alu_from_f3(f3, f7[5]);
        end
      end
      OP_REG: begin
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.opb_sel = OpbRs2;
        case (f7)
          7'h00: ctrl_o.alu_op = alu_from_f3(f3, 1'b0);
          7'h20: begin
            ill           = (f3 != 3'b000) && (f3 != 3'b101);
            ctrl_o.alu_op = alu_from_f3(f3, 1'b1);
          end
          7'h01: begin
            ill           = !EN_M;
            ctrl_o.alu_op = alu_op_e'(5'd10 + {2'b00, f3});
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase

    // Illegal encodings must not cause any architectural side effect downstream.
    if (ill || (instr_i[1:0] != 2'b11)) begin
      ctrl_o    = '0;
      illegal_o = 1'b1;
    end else begin
      ctrl_o.funct3   = f3;
      ctrl_o.insn_vld = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode pipeline stage with valid/ready handshake and a one-entry skid buffer.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          EN_M     = 1'b0,
  parameter int unsigned ALU_OP_W = decode_pkg::ALU_OP_W
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output ctrl_t           o_ctrl,
  output logic            o_illegal
);

  if (ALU_OP_W != $bits(alu_op_e)) begin : g_alu_op_w_check
    $error("ALU_OP_W must equal the width of decode_pkg::alu_op_e");
  end

  ctrl_t dec_ctrl;
  logic  dec_ill;

  instr_decoder #(
    .EN_M(EN_M)
  ) u_instr_decoder (
    .instr_i  (i_instr),
    .ctrl_o   (dec_ctrl),
    .illegal_o(dec_ill)
  );

  logic            out_vld_q, out_vld_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  ctrl_t           out_ctrl_q, out_ctrl_d;
  logic            out_ill_q, out_ill_d;

  logic            skid_vld_q, skid_vld_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  ctrl_t           skid_ctrl_q, skid_ctrl_d;
  logic            skid_ill_q, skid_ill_d;

  logic accept;
  logic out_free;

  assign accept   = i_valid & ~skid_vld_q;
  assign out_free = ~out_vld_q | i_ready;

  always_comb begin
    out_vld_d    = out_vld_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_ctrl_d   = out_ctrl_q;
    out_ill_d    = out_ill_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_ill_d   = skid_ill_q;

    if (i_flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_free) begin
      // Skid entry is older than anything upstream, so it drains first.
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_instr_d = skid_instr_q;
        out_pc_d    = skid_pc_q;
        out_ctrl_d  = skid_ctrl_q;
        out_ill_d   = skid_ill_q;
        skid_vld_d  = 1'b0;
      end else begin
        out_vld_d = accept;
        if (accept) begin
          out_instr_d = i_instr;
          out_pc_d    = i_pc;
          out_ctrl_d  = dec_ctrl;
          out_ill_d   = dec_ill;
        end
      end
    end else if (accept) begin
      skid_vld_d   = 1'b1;
      skid_instr_d = i_instr;
      skid_pc_d    = i_pc;
      skid_ctrl_d  = dec_ctrl;
      skid_ill_d   = dec_ill;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_vld_q    <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_ctrl_q   <= '0;
      out_ill_q    <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_ctrl_q  <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_ctrl_q   <= out_ctrl_d;
      out_ill_q    <= out_ill_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign o_ready   = ~skid_vld_q;
  assign o_valid   = out_vld_q;
  assign o_instr   = out_instr_q;
  assign o_pc      = out_pc_q;
  assign o_ctrl    = out_ctrl_q;
  assign o_illegal = out_ill_q;

endmodule
